// File: rtl/enoc_route_calc_pipe_pkg.sv
// Shared definitions for the ENoC route calculator: port indices, routing modes,
// the dimension-order permutation table and the one-hot request helper.
package enoc_route_pkg;

    localparam int M_MAX = 7;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_YP    = 3'd1;
    localparam logic [2:0] PORT_XP    = 3'd2;
    localparam logic [2:0] PORT_YM    = 3'd3;
    localparam logic [2:0] PORT_XM    = 3'd4;
    localparam logic [2:0] PORT_ZM    = 3'd5;
    localparam logic [2:0] PORT_ZP    = 3'd6;

    typedef enum logic [1:0] {
        MODE_DOR      = 2'd0,
        MODE_ROTATE   = 2'd1,
        MODE_ADAPTIVE = 2'd2
    } route_mode_e;

    localparam logic [1:0] DIM_X = 2'd0;
    localparam logic [1:0] DIM_Y = 2'd1;
    localparam logic [1:0] DIM_Z = 2'd2;

    // PERM_3D[p][s] is the dimension tried in slot s of order p:
    // 0 XYZ, 1 XZY, 2 ZXY, 3 ZYX, 4 YZX, 5 YXZ. 2D uses entries 0 (XY) and 5 (YX).
    localparam logic [5:0][2:0][1:0] PERM_3D = {
        {DIM_Z, DIM_X, DIM_Y},
        {DIM_X, DIM_Z, DIM_Y},
        {DIM_X, DIM_Y, DIM_Z},
        {DIM_Y, DIM_X, DIM_Z},
        {DIM_Y, DIM_Z, DIM_X},
        {DIM_Z, DIM_Y, DIM_X}
    };

    function automatic logic [0:M_MAX-1] onehot(input logic [2:0] idx, input int m);
        logic [0:M_MAX-1] r;
        for (int p = 0; p < M_MAX; p++) begin
            r[p] = (p < m) && (idx == 3'(p));
        end
        return r;
    endfunction

endpackage

// File: rtl/enoc_route_calc_pipe_if.sv
// Input-buffer / switch-allocator handshake bundle of the route calculator.
// master = surrounding router logic, slave = the route calculator itself.
interface enoc_route_calc_pipe_if #(
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int Z_W      = 1,
    parameter int M        = 5,
    parameter int CREDIT_W = 4,
    parameter int TAG_W    = 8
);
    logic [X_W-1:0]                 i_x_dest;
    logic [Y_W-1:0]                 i_y_dest;
    logic [Z_W-1:0]                 i_z_dest;
    logic [TAG_W-1:0]               i_tag;
    logic                           i_val;
    logic                           o_rdy;
    logic [0:M-1][CREDIT_W-1:0]     i_credits;
    logic [0:M-1]                   o_output_req;
    logic [TAG_W-1:0]               o_tag;
    logic                           o_val;
    logic                           i_rdy;
    logic                           o_err;

    modport master (
        output i_x_dest, i_y_dest, i_z_dest, i_tag, i_val, i_credits, i_rdy,
        input  o_rdy, o_output_req, o_tag, o_val, o_err
    );

    modport slave (
        input  i_x_dest, i_y_dest, i_z_dest, i_tag, i_val, i_credits, i_rdy,
        output o_rdy, o_output_req, o_tag, o_val, o_err
    );
endinterface

// File: rtl/enoc_route_calc_pipe_dim_dir.sv
// One routing dimension: is the destination legal, does this dimension still
// need hops, and which direction is minimal (mesh or wrap-around torus).
module enoc_dim_dir #(
    parameter int N     = 4,
    parameter int LOC   = 0,
    parameter int TORUS = 0,
    localparam int W    = $clog2(N)
) (
    input  logic [W-1:0] dest,
    output logic         productive,
    output logic         plus,
    output logic         legal
);

    logic [W:0]   dest_ext;
    logic [W:0]   raw;
    logic [W:0]   fwd;
    logic [W+1:0] twice_fwd;

    // fwd is the forward hop distance (dest - LOC) mod N; a tie goes to the + direction.
    always_comb begin
        dest_ext   = {1'b0, dest};
        raw        = dest_ext + (W+1)'(N - LOC);
        fwd        = (raw >= (W+1)'(N)) ? raw - (W+1)'(N) : raw;
        twice_fwd  = {fwd, 1'b0};
        legal      = dest_ext < (W+1)'(N);
        productive = dest != W'(LOC);
        if (TORUS != 0) begin
            plus = twice_fwd <= (W+2)'(N);
        end else begin
            plus = dest > W'(LOC);
        end
    end

endmodule

// File: rtl/enoc_route_calc_pipe.sv
// Registered route calculator for one router input port: DOR, rotating
// dimension order or credit-adaptive minimal routing, one-stage valid/ready.
module enoc_route_calc_pipe
    import enoc_route_pkg::*;
#(
    parameter int X_NODES  = 4,
    parameter int Y_NODES  = 4,
    parameter int Z_NODES  = 1,
    parameter int X_LOC    = 0,
    parameter int Y_LOC    = 0,
    parameter int Z_LOC    = 0,
    parameter int TORUS    = 0,
    parameter int MODE     = 0,
    parameter int CREDIT_W = 4,
    parameter int TAG_W    = 8
) (
    input logic               clk,
    input logic               reset,
    enoc_route_calc_pipe_if.slave bus
);

    localparam int M       = (Z_NODES > 1) ? 7 : 5;
    localparam int PTR_MAX = (Z_NODES > 1) ? 6 : 2;
    localparam route_mode_e ROUTE_MODE = route_mode_e'(MODE[1:0]);

    logic x_prod, x_plus, x_legal;
    logic y_prod, y_plus, y_legal;
    logic z_prod, z_plus, z_legal;
    logic legal, rdy, accept, load;
    logic [2:0] ptr_q, ptr_next;
    logic [2:0][1:0] order;
    logic [3:0] dim_prod;
    logic [3:0][2:0] dim_port;
    logic [2:0] dor_port, rot_port, ada_port, route_port;
    logic rot_found;
    logic [CREDIT_W-1:0] best_credit;
    logic [0:M_MAX-1] req_full;
    logic val_q, err_q;
    logic [0:M-1] req_q;
    logic [TAG_W-1:0] tag_q;

    enoc_dim_dir #(.N(X_NODES), .LOC(X_LOC), .TORUS(TORUS)) u_dim_x (
        .dest(bus.i_x_dest), .productive(x_prod), .plus(x_plus), .legal(x_legal)
    );

    enoc_dim_dir #(.N(Y_NODES), .LOC(Y_LOC), .TORUS(TORUS)) u_dim_y (
        .dest(bus.i_y_dest), .productive(y_prod), .plus(y_plus), .legal(y_legal)
    );

    if (Z_NODES > 1) begin : g_z
        enoc_dim_dir #(.N(Z_NODES), .LOC(Z_LOC), .TORUS(TORUS)) u_dim_z (
            .dest(bus.i_z_dest), .productive(z_prod), .plus(z_plus), .legal(z_legal)
        );
    end else begin : g_no_z
        assign z_prod  = 1'b0;
        assign z_plus  = 1'b0;
        assign z_legal = 1'b1;
    end

    assign legal  = x_legal & y_legal & z_legal;
    assign rdy    = ~val_q | bus.i_rdy;
    assign accept = bus.i_val & rdy;
    assign load   = accept & legal;

    // Candidate port per dimension code; code 3 is a never-productive pad entry.
    always_comb begin
        dim_prod    = {1'b0, z_prod, y_prod, x_prod};
        dim_port[0] = x_plus ? PORT_XP : PORT_XM;
        dim_port[1] = y_plus ? PORT_YP : PORT_YM;
        dim_port[2] = z_plus ? PORT_ZP : PORT_ZM;
        dim_port[3] = PORT_LOCAL;

        if (x_prod)      dor_port = dim_port[0];
        else if (y_prod) dor_port = dim_port[1];
        else if (z_prod) dor_port = dim_port[2];
        else             dor_port = PORT_LOCAL;
    end

    always_comb begin
        if (Z_NODES > 1) begin
            order = PERM_3D[ptr_q];
        end else begin
            order = (ptr_q == 3'd0) ? PERM_3D[0] : PERM_3D[5];
        end
        rot_port  = PORT_LOCAL;
        rot_found = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (!rot_found && dim_prod[order[s]]) begin
                rot_port  = dim_port[order[s]];
                rot_found = 1'b1;
            end
        end
    end

    // Strict '>' keeps ties on the earlier dimension and never picks a zero-credit
    // port, so an all-zero productive set falls through to the DOR choice.
    always_comb begin
        ada_port    = dor_port;
        best_credit = '0;
        for (int d = 0; d < 3; d++) begin
            if (dim_prod[d] && (bus.i_credits[dim_port[d]] > best_credit)) begin
                best_credit = bus.i_credits[dim_port[d]];
                ada_port    = dim_port[d];
            end
        end
    end

    always_comb begin
        case (ROUTE_MODE)
            MODE_DOR:    route_port = dor_port;
            MODE_ROTATE: route_port = rot_port;
            default:     route_port = ada_port;
        endcase
        req_full = onehot(route_port, M);
        ptr_next = (ptr_q == 3'(PTR_MAX - 1)) ? 3'd0 : ptr_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= 1'b0;
            req_q <= '0;
            tag_q <= '0;
            err_q <= 1'b0;
            ptr_q <= 3'd0;
        end else begin
            err_q <= accept & ~legal;
            if (rdy) begin
                val_q <= load;
                if (load) begin
                    req_q <= req_full[0:M-1];
                    tag_q <= bus.i_tag;
                end else begin
                    req_q <= '0;
                end
            end
            if (load) begin
                ptr_q <= ptr_next;
            end
        end
    end

    assign bus.o_rdy        = rdy;
    assign bus.o_val        = val_q;
    assign bus.o_output_req = req_q;
    assign bus.o_tag        = tag_q;
    assign bus.o_err        = err_q;

endmodule
